// File: rtl/nes_loader_pkg.sv
// Shared types and constants for the iNES ROM loader: FSM states, header magic,
// region sizes and the byte-offset counter width.
package nes_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        TRAINER,
        PRG,
        CHR,
        EXTRA,
        ERROR,
        DRAIN
    } state_t;

    localparam int CNT_W   = 23;
    localparam int ENTRY_W = 30;

    localparam logic [31:0]      INES_MAGIC     = 32'h4E45531A;
    localparam logic [CNT_W-1:0] HEADER_BYTES   = 23'd16;
    localparam logic [CNT_W-1:0] PRG_BANK_BYTES = 23'd16384;
    localparam logic [CNT_W-1:0] CHR_BANK_BYTES = 23'd8192;
    localparam logic [CNT_W-1:0] TRAINER_BYTES  = 23'd512;
    localparam logic [CNT_W-1:0] REGION_LIMIT   = 23'h200000;

    // Byte length of a region given its bank count; 255 PRG banks still fits CNT_W.
    function automatic logic [CNT_W-1:0] region_bytes(input logic [7:0]       banks,
                                                      input logic [CNT_W-1:0] unit);
        return {{(CNT_W-8){1'b0}}, banks} * unit;
    endfunction

endpackage

// File: rtl/loader_fifo.sv
// Synchronous FIFO between the byte parser and the stallable memory write port.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module loader_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 8
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (!reset_n || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/nes_rom_loader.sv
// Parses an iNES image arriving on the HPS ioctl byte stream, skips any trainer,
// and forwards PRG/CHR payload through a FIFO to a stallable memory write port.
module nes_rom_loader
    import nes_loader_pkg::*;
#(
    parameter logic [7:0]  ROM_INDEX  = 8'd0,
    parameter logic [21:0] CHR_BASE   = 22'h200000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wr,
    input  logic        mem_ack,
    output logic        busy,
    output logic        load_done,
    output logic        header_valid,
    output logic [7:0]  mapper,
    output logic [7:0]  prg_banks,
    output logic [7:0]  chr_banks,
    output logic        mirroring,
    output logic        err_header,
    output logic        err_overflow
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_dl_prev;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_hdr [8];
    logic               r_busy;
    logic               r_load_done;
    logic               r_header_valid;
    logic               r_err_header;
    logic               r_err_overflow;
    logic [7:0]         r_mapper;
    logic [7:0]         r_prg_banks;
    logic [7:0]         r_chr_banks;
    logic               r_mirroring;

    logic               w_start;
    logic               w_dl_fall;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_region_len;
    logic               w_last;
    logic               w_hdr_ok;
    logic               w_count;
    logic               w_hdr_store;
    logic               w_hdr_done;
    logic               w_push;
    logic [21:0]        w_push_addr;
    logic               w_done;
    logic               w_full;
    logic               w_empty;
    logic               w_pop_ok;
    logic               w_overflow;
    logic               w_mem_wr;
    logic [ENTRY_W-1:0] w_head;

    assign w_start   = ioctl_download & ~r_dl_prev & (ioctl_index == ROM_INDEX);
    assign w_dl_fall = ~ioctl_download & r_dl_prev;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last    = (w_cnt_inc == w_region_len);
    assign w_hdr_ok  = ({r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3]} == INES_MAGIC) &&
                       (r_hdr[4] != 8'd0);

    always_comb begin
        w_region_len = '1;
        unique case (r_state)
            HEADER:  w_region_len = HEADER_BYTES;
            TRAINER: w_region_len = TRAINER_BYTES;
            PRG:     w_region_len = region_bytes(r_prg_banks, PRG_BANK_BYTES);
            CHR:     w_region_len = region_bytes(r_chr_banks, CHR_BANK_BYTES);
            default: ;
        endcase
    end

    // Next-state and per-byte strobes; a new load start overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_count      = 1'b0;
        w_hdr_store  = 1'b0;
        w_hdr_done   = 1'b0;
        w_push       = 1'b0;
        w_push_addr  = '0;
        w_done       = 1'b0;
        if (w_start) begin
            w_state_next = HEADER;
        end else if (w_dl_fall && (r_state != IDLE)) begin
            w_state_next = DRAIN;
        end else begin
            unique case (r_state)
                HEADER: begin
                    if (ioctl_wr) begin
                        w_count     = 1'b1;
                        w_hdr_store = (r_cnt < 23'd8);
                        if (w_last) begin
                            w_hdr_done = 1'b1;
                            if (!w_hdr_ok)      w_state_next = ERROR;
                            else if (r_hdr[6][2]) w_state_next = TRAINER;
                            else                w_state_next = PRG;
                        end
                    end
                end
                TRAINER: begin
                    if (ioctl_wr) begin
                        w_count = 1'b1;
                        if (w_last) w_state_next = PRG;
                    end
                end
                PRG: begin
                    if (ioctl_wr) begin
                        w_count     = 1'b1;
                        w_push      = (r_cnt < REGION_LIMIT);
                        w_push_addr = r_cnt[21:0];
                        if (w_last) w_state_next = (r_chr_banks != 8'd0) ? CHR : EXTRA;
                    end
                end
                CHR: begin
                    if (ioctl_wr) begin
                        w_count     = 1'b1;
                        w_push      = (r_cnt < REGION_LIMIT);
                        w_push_addr = CHR_BASE + r_cnt[21:0];
                        if (w_last) w_state_next = EXTRA;
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        w_state_next = IDLE;
                        w_done       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_dl_prev      <= 1'b0;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_load_done    <= 1'b0;
            r_header_valid <= 1'b0;
            r_err_header   <= 1'b0;
            r_err_overflow <= 1'b0;
            r_mapper       <= '0;
            r_prg_banks    <= '0;
            r_chr_banks    <= '0;
            r_mirroring    <= 1'b0;
        end else begin
            r_dl_prev   <= ioctl_download;
            r_busy      <= (w_state_next != IDLE);
            r_load_done <= w_done;
            if (w_start) begin
                r_cnt          <= '0;
                r_header_valid <= 1'b0;
                r_err_header   <= 1'b0;
                r_err_overflow <= 1'b0;
            end else begin
                if (w_count) r_cnt <= w_last ? '0 : w_cnt_inc;
                if (w_hdr_done) begin
                    r_mapper       <= {r_hdr[7][7:4], r_hdr[6][7:4]};
                    r_prg_banks    <= r_hdr[4];
                    r_chr_banks    <= r_hdr[5];
                    r_mirroring    <= r_hdr[6][0];
                    r_header_valid <= w_hdr_ok;
                    r_err_header   <= ~w_hdr_ok;
                end
                if (w_overflow) r_err_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_hdr_store) r_hdr[r_cnt[2:0]] <= ioctl_dout;
    end

    assign w_pop_ok   = mem_ack & ~w_empty;
    assign w_overflow = w_push & w_full & ~w_pop_ok;

    loader_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_flush (w_start),
        .i_push  (w_push),
        .i_data  ({w_push_addr, ioctl_dout}),
        .i_pop   (mem_ack),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Reset gates the request combinationally so it drops in the reset cycle itself.
    assign w_mem_wr     = ~w_empty & reset_n;
    assign mem_wr       = w_mem_wr;
    assign mem_addr     = w_mem_wr ? w_head[29:8] : 22'd0;
    assign mem_data     = w_mem_wr ? w_head[7:0]  : 8'd0;
    assign busy         = r_busy;
    assign load_done    = r_load_done;
    assign header_valid = r_header_valid;
    assign mapper       = r_mapper;
    assign prg_banks    = r_prg_banks;
    assign chr_banks    = r_chr_banks;
    assign mirroring    = r_mirroring;
    assign err_header   = r_err_header;
    assign err_overflow = r_err_overflow;

endmodule

// File: doc/nes_rom_loader.md
# nes_rom_loader

Downstream consumer of the HPS file-download stream (`ioctl_*`, byte mode) that turns an uploaded iNES image into memory writes and cartridge configuration. It parses the 16-byte iNES header and skips any trainer. PRG and CHR payload bytes go through a small FIFO to a stallable memory write port. Decoded mapper/size/mirroring fields are presented to the mapper logic.

## Interface
Parameters:
- `ROM_INDEX`, 8'd0: `ioctl_index` value that selects this loader; other indices are ignored.
- `CHR_BASE`, 22'h200000: memory byte address of CHR region; PRG region starts at 0.
- `FIFO_DEPTH`, 8: buffer entries (power of two, ≥2).

Ports:
- `clk_sys`  in  1  system clock; one clock domain, everything synchronous to it.
- `reset_n`  in  1  synchronous, active-low reset.
- `ioctl_download`  in  1  download active level.
- `ioctl_index`  in  8  file index.
- `ioctl_wr`  in  1  one-cycle byte strobe; no backpressure possible.
- `ioctl_dout`  in  8  byte data.
- `mem_addr`  out  22  write address.
- `mem_data`  out  8  write data.
- `mem_wr`  out  1  write request, held until acked.
- `mem_ack`  in  1  accept for the current request.
- `busy`  out  1  load in progress, including drain.
- `load_done`  out  1  one-cycle pulse when load finishes.
- `header_valid`  out  1  header parsed and accepted.
- `mapper`  out  8  `{hdr7[7:4], hdr6[7:4]}`.
- `prg_banks`  out  8  header byte 4 (16 KiB units).
- `chr_banks`  out  8  header byte 5 (8 KiB units, 0 = CHR-RAM).
- `mirroring`  out  1  header byte 6 bit 0.
- `err_header`  out  1  sticky: bad magic or `prg_banks`=0.
- `err_overflow`  out  1  sticky: byte arrived with FIFO full.

## Operation
- Reset: all outputs 0, state IDLE, FIFO empty, sticky errors cleared.
- A load starts on the rising edge of `ioctl_download` when `ioctl_index`==`ROM_INDEX`. It clears the errors, `header_valid`, the byte counter and the FIFO, and enters HEADER. A rising edge in any state, including DRAIN, aborts the current load and restarts.
- States and transitions:
  - IDLE
  - HEADER: 16 bytes, stored in registers.
  - After HEADER: if magic ≠ "NES",0x1A or byte4=0, set `err_header` and go to ERROR. Otherwise go to TRAINER if hdr6[2], else PRG.
  - TRAINER: 512 bytes discarded, then PRG.
  - PRG: `prg_banks`×16384 bytes pushed at addresses 0.., then CHR if `chr_banks`≠0, else EXTRA.
  - CHR: `chr_banks`×8192 bytes pushed at `CHR_BASE`+offset, then EXTRA.
  - EXTRA: bytes discarded.
  - ERROR: bytes discarded.
- Header fields update on the byte-15 strobe. `header_valid` rises the next cycle if the checks pass.
- PRG beyond 2 MiB (byte4 > 128) is truncated: bytes whose offset ≥ 0x200000 are discarded. CHR beyond 2 MiB is truncated the same way. Offsets never wrap into the other region.
- Falling edge of `ioctl_download` from any non-IDLE state goes to DRAIN. DRAIN waits until the FIFO is empty, then pulses `load_done`, clears `busy` and returns to IDLE. Error flags and decoded fields hold until the next load start.
- Short file (download ends mid-region): same DRAIN path, no extra error flag.
- FIFO entry = {22-bit addr, 8-bit data}.
  - A push with FIFO full drops the byte and sets `err_overflow`.
  - A push and a pop in the same cycle when full succeeds.

## Timing
- `ioctl_wr` is sampled on `clk_sys`. A payload byte is written into the FIFO on that edge.
- FIFO empty → `mem_wr` high with that byte on the following cycle (1-cycle latency).
- `mem_wr`/`mem_addr`/`mem_data` stay stable while `mem_wr`=1 and `mem_ack`=0.
- `mem_ack`=1 pops the entry on that edge. If another entry exists, it is presented the next cycle with `mem_wr` staying high; sustained throughput is 1 byte/cycle.
- `mem_ack` while `mem_wr`=0 is ignored.
- `busy` rises the cycle after the load-start edge and falls in the same cycle as `load_done`.
- Reset mid-load drops `mem_wr` immediately and discards FIFO contents.

## Structure
- Package `nes_loader_pkg` holds:
  - the state enum (IDLE, HEADER, TRAINER, PRG, CHR, EXTRA, ERROR, DRAIN);
  - `INES_MAGIC`=32'h4E45531A;
  - the bank sizes 16384/8192, the trainer length 512 and the region limit 0x200000.
- Sub-module `loader_fifo`: a synchronous FIFO, 30 bits wide, with `FIFO_DEPTH` entries, full/empty outputs and simultaneous push/pop.

## Test plan
- Valid header: 4E 45 53 1A 02 01 01 00 … followed by 32768+8192 bytes, with `mem_ack` always 1.
  - Expect `mapper`=0, `prg_banks`=2, `chr_banks`=1, `mirroring`=1.
  - Expect PRG writes at 0..0x7FFF and CHR writes at 0x200000..0x201FFF.
  - Expect a single `load_done`.
- Trainer: byte6=0x04. The first PRG write carries file byte 528 at address 0.
- Bad magic 4E 45 53 00 → `err_header`=1, zero `mem_wr` cycles, `load_done` after the download ends.
- Backpressure: `mem_ack` low for 8 cycles during a continuous byte stream.
  - `FIFO_DEPTH` bytes are buffered and the 9th sets `err_overflow`.
  - The order of the buffered bytes is preserved.
- `chr_banks`=0 with 100 trailing bytes → no writes at or above `CHR_BASE`.
- `ioctl_index`=1 → no activity at all.
- `reset_n` low mid-PRG → all outputs 0 next cycle; a new load afterwards succeeds.
